// File: rtl/ysyx_22050019_axi_rr_arb.sv
// N-master to 1-slave AXI-lite arbiter with independent round-robin read and write schedulers.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module ysyx_22050019_axi_rr_arb #(
  parameter int NM      = 2,
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NM-1:0]      m_ar_valid_i,
  output logic [NM-1:0]      m_ar_ready_o,
  input  logic [NM*AW-1:0]   m_ar_addr_i,
  output logic [NM-1:0]      m_r_valid_o,
  input  logic [NM-1:0]      m_r_ready_i,
  output logic [1:0]         m_r_resp_o,
  output logic [DW-1:0]      m_r_data_o,
  input  logic [NM-1:0]      m_aw_valid_i,
  output logic [NM-1:0]      m_aw_ready_o,
  input  logic [NM*AW-1:0]   m_aw_addr_i,
  input  logic [NM-1:0]      m_w_valid_i,
  output logic [NM-1:0]      m_w_ready_o,
  input  logic [NM*DW-1:0]   m_w_data_i,
  input  logic [NM*DW/8-1:0] m_w_strb_i,
  output logic [NM-1:0]      m_b_valid_o,
  input  logic [NM-1:0]      m_b_ready_i,
  output logic [1:0]         m_b_resp_o,
  output logic               s_ar_valid_o,
  input  logic               s_ar_ready_i,
  output logic [AW-1:0]      s_ar_addr_o,
  input  logic               s_r_valid_i,
  output logic               s_r_ready_o,
  input  logic [1:0]         s_r_resp_i,
  input  logic [DW-1:0]      s_r_data_i,
  output logic               s_aw_valid_o,
  input  logic               s_aw_ready_i,
  output logic [AW-1:0]      s_aw_addr_o,
  output logic               s_w_valid_o,
  input  logic               s_w_ready_i,
  output logic [DW-1:0]      s_w_data_o,
  output logic [DW/8-1:0]    s_w_strb_o,
  input  logic               s_b_valid_i,
  output logic               s_b_ready_o,
  input  logic [1:0]         s_b_resp_i,
  output logic               timeout_o
);
  // Handshakes: a beat transfers on a rising clk edge where valid and ready are both high;
  // valid never waits on ready, and the arbiter only combines the granted master's signals.
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  if (NM < 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("ysyx_22050019_axi_rr_arb: NM or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_e;

  r_state_e r_state, r_next;
  w_state_e w_state, w_next;
  logic [PW-1:0] rgnt, rd_ptr, wgnt, wr_ptr;
  logic aw_done, w_done, aw_fire, w_fire;
  logic [NM-1:0] w_req;

  function automatic logic [PW-1:0] rr_pick(input logic [NM-1:0] req, input logic [PW-1:0] ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NM; i++) begin
      idx = (int'(ptr) + i) % NM;
      if (!found && req[idx]) begin
        rr_pick = idx[PW-1:0];
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] g);
    if (int'(g) == NM - 1) return '0;
    return g + 1'b1;
  endfunction

  assign w_req = m_aw_valid_i | m_w_valid_i;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] r_cnt, w_cnt;
  logic r_expired, w_expired, r_tmo_fire, w_tmo_fire;
  logic r_orphan, w_orphan, tmo_q;
  assign r_expired = (r_cnt == 16'(TIMEOUT));
  assign w_expired = (w_cnt == 16'(TIMEOUT));
  assign timeout_o = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      w_cnt    <= '0;
      r_orphan <= 1'b0;
      w_orphan <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      r_cnt <= (r_state != R_DATA) ? '0 : (r_expired ? r_cnt : r_cnt + 1'b1);
      w_cnt <= (w_state != W_RESP) ? '0 : (w_expired ? w_cnt : w_cnt + 1'b1);
      // A response abandoned by the watchdog may still arrive later; swallow it in IDLE.
      if (r_tmo_fire) r_orphan <= 1'b1;
      else if (r_state == R_IDLE && s_r_valid_i) r_orphan <= 1'b0;
      if (w_tmo_fire) w_orphan <= 1'b1;
      else if (w_state == W_IDLE && s_b_valid_i) w_orphan <= 1'b0;
      tmo_q <= tmo_q | r_tmo_fire | w_tmo_fire;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

  // Read scheduler
  always_comb begin
    r_next       = r_state;
    m_ar_ready_o = '0;
    m_r_valid_o  = '0;
    m_r_resp_o   = '0;
    m_r_data_o   = '0;
    s_ar_valid_o = 1'b0;
    s_ar_addr_o  = '0;
    s_r_ready_o  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    r_tmo_fire   = 1'b0;
`endif
    case (r_state)
      R_IDLE: begin
        if (|m_ar_valid_i) r_next = R_ADDR;
`ifdef ARB_TIMEOUT_EN
        s_r_ready_o = r_orphan;
`endif
      end
      R_ADDR: begin
        s_ar_valid_o       = m_ar_valid_i[rgnt];
        s_ar_addr_o        = m_ar_addr_i[rgnt*AW +: AW];
        m_ar_ready_o[rgnt] = s_ar_ready_i;
        if (s_ar_valid_o && s_ar_ready_i) r_next = R_DATA;
      end
      R_DATA: begin
        m_r_valid_o[rgnt] = s_r_valid_i;
        s_r_ready_o       = m_r_ready_i[rgnt];
        m_r_resp_o        = s_r_resp_i;
        m_r_data_o        = s_r_data_i;
        if (s_r_valid_i && m_r_ready_i[rgnt]) r_next = R_IDLE;
`ifdef ARB_TIMEOUT_EN
        if (r_expired && !s_r_valid_i) begin
          m_r_valid_o[rgnt] = 1'b1;
          s_r_ready_o       = 1'b0;
          m_r_resp_o        = 2'b10;
          m_r_data_o        = '0;
          if (m_r_ready_i[rgnt]) begin
            r_next     = R_IDLE;
            r_tmo_fire = 1'b1;
          end
        end
`endif
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rgnt    <= '0;
      rd_ptr  <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && |m_ar_valid_i) rgnt <= rr_pick(m_ar_valid_i, rd_ptr);
      if (r_state == R_DATA && r_next == R_IDLE) rd_ptr <= next_idx(rgnt);
    end
  end

  // Write scheduler: AW and W complete independently before the B phase
  always_comb begin
    w_next       = w_state;
    aw_fire      = 1'b0;
    w_fire       = 1'b0;
    m_aw_ready_o = '0;
    m_w_ready_o  = '0;
    m_b_valid_o  = '0;
    m_b_resp_o   = '0;
    s_aw_valid_o = 1'b0;
    s_aw_addr_o  = '0;
    s_w_valid_o  = 1'b0;
    s_w_data_o   = '0;
    s_w_strb_o   = '0;
    s_b_ready_o  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_tmo_fire   = 1'b0;
`endif
    case (w_state)
      W_IDLE: begin
        if (|w_req) w_next = W_XFER;
`ifdef ARB_TIMEOUT_EN
        s_b_ready_o = w_orphan;
`endif
      end
      W_XFER: begin
        s_aw_valid_o       = !aw_done && m_aw_valid_i[wgnt];
        s_aw_addr_o        = m_aw_addr_i[wgnt*AW +: AW];
        m_aw_ready_o[wgnt] = !aw_done && s_aw_ready_i;
        s_w_valid_o        = !w_done && m_w_valid_i[wgnt];
        s_w_data_o         = m_w_data_i[wgnt*DW +: DW];
        s_w_strb_o         = m_w_strb_i[wgnt*SW +: SW];
        m_w_ready_o[wgnt]  = !w_done && s_w_ready_i;
        aw_fire            = s_aw_valid_o && s_aw_ready_i;
        w_fire             = s_w_valid_o && s_w_ready_i;
        if ((aw_done || aw_fire) && (w_done || w_fire)) w_next = W_RESP;
      end
      W_RESP: begin
        m_b_valid_o[wgnt] = s_b_valid_i;
        s_b_ready_o       = m_b_ready_i[wgnt];
        m_b_resp_o        = s_b_resp_i;
        if (s_b_valid_i && m_b_ready_i[wgnt]) w_next = W_IDLE;
`ifdef ARB_TIMEOUT_EN
        if (w_expired && !s_b_valid_i) begin
          m_b_valid_o[wgnt] = 1'b1;
          s_b_ready_o       = 1'b0;
          m_b_resp_o        = 2'b10;
          if (m_b_ready_i[wgnt]) begin
            w_next     = W_IDLE;
            w_tmo_fire = 1'b1;
          end
        end
`endif
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      wgnt    <= '0;
      wr_ptr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (|w_req) wgnt <= rr_pick(w_req, wr_ptr);
      end else if (w_state == W_XFER) begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (w_state == W_RESP && w_next == W_IDLE) wr_ptr <= next_idx(wgnt);
    end
  end

endmodule

// File: doc/ysyx_22050019_axi_rr_arb.md
Name: ysyx_22050019_axi_rr_arb

Overview:
- N-master to 1-slave AXI-lite arbiter with round-robin fairness.
- Independent read and write channel schedulers.
- Sits between the instruction cache, the LSU and future masters (dcache, DMA) on one side, and the shared AXI-lite SRAM slave on the other.
- Supersedes the fixed-priority read-only arbitration: the write channel is also arbitrated, and a grant is held until the response handshake completes.

Parameters:
- NM, 2, number of masters; index 0 = icache, 1 = LSU.
- AW, 64, address width.
- DW, 64, data width; strobe width is DW/8.
- TIMEOUT, 255, response watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_ar_valid_i  in  NM  per-master AR valid
- m_ar_ready_o  out  NM  per-master AR ready
- m_ar_addr_i  in  NM*AW  packed AR addresses; master k occupies bits [k*AW +: AW]
- m_r_valid_o  out  NM  per-master R valid
- m_r_ready_i  in  NM  per-master R ready
- m_r_resp_o  out  2  R response, broadcast to all masters
- m_r_data_o  out  DW  R data, broadcast to all masters
- m_aw_valid_i / m_aw_ready_o  in/out  NM  per-master AW handshake
- m_aw_addr_i  in  NM*AW  packed AW addresses
- m_w_valid_i / m_w_ready_o  in/out  NM  per-master W handshake
- m_w_data_i  in  NM*DW  packed write data
- m_w_strb_i  in  NM*DW/8  packed write strobes
- m_b_valid_o / m_b_ready_i  out/in  NM  per-master B handshake
- m_b_resp_o  out  2  B response, broadcast to all masters
- s_ar_valid_o / s_ar_ready_i / s_ar_addr_o  out/in/out  1/1/AW  slave AR
- s_r_valid_i / s_r_ready_o / s_r_resp_i / s_r_data_i  in/out/in/in  1/1/2/DW  slave R
- s_aw_valid_o / s_aw_ready_i / s_aw_addr_o  out/in/out  1/1/AW  slave AW
- s_w_valid_o / s_w_ready_i / s_w_data_o / s_w_strb_o  out/in/out/out  1/1/DW/DW/8  slave W
- s_b_valid_i / s_b_ready_o / s_b_resp_i  in/out/in  1/1/2  slave B
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset: async assert on rst_n=0. All valid/ready outputs 0, data/addr/resp/strb outputs 0, both FSMs in IDLE, rd_ptr = wr_ptr = 0, timeout_o = 0.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: if any m_ar_valid_i is set, register rgnt = first set bit searching from rd_ptr upward with wrap, then go to R_ADDR. Selection is registered, so s_ar_valid_o rises at the earliest one cycle after m_ar_valid_i.
  - R_ADDR: s_ar_valid_o = m_ar_valid_i[rgnt], s_ar_addr_o = address of rgnt, m_ar_ready_o[rgnt] = s_ar_ready_i. On s_ar_valid_o & s_ar_ready_i, go to R_DATA.
  - R_DATA: m_r_valid_o[rgnt] = s_r_valid_i, s_r_ready_o = m_r_ready_i[rgnt], resp/data passed through. On the R handshake, go to R_IDLE and set rd_ptr = (rgnt+1) mod NM.
- Write FSM states: W_IDLE, W_XFER, W_RESP.
  - W_IDLE: a request is any m_aw_valid_i | m_w_valid_i. Grant wgnt by the same round-robin using wr_ptr.
  - W_XFER: AW and W are forwarded independently, with done flags aw_done and w_done; a channel's valid drops after its handshake. Go to W_RESP when both are done, including the same cycle.
  - W_RESP: route B to wgnt. On the B handshake, go to W_IDLE and set wr_ptr = (wgnt+1) mod NM.
- Read and write FSMs are fully independent. One master may hold both grants at once.
- Non-granted masters always see ready = 0 and valid = 0. Outputs in IDLE states: slave-side valids = 0, s_r_ready_o = s_b_ready_o = 0.
- A master that deasserts valid in R_ADDR or W_XFER (an AXI violation) keeps its grant. The arbiter waits and does not abort.
- Single-master case (only one requester): back-to-back transactions cost 1 idle cycle each (the IDLE state).
- rst_n asserted mid-transaction: immediate return to IDLE. The in-flight transaction is dropped and the slave is assumed reset together with the arbiter.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8..16-bit counter runs in R_DATA and W_RESP and clears on each state entry.
  - If the count reaches TIMEOUT without a slave response, the arbiter itself drives the granted master's r/b valid with resp = 2'b10 (SLVERR) and data = 0, completes that handshake, returns to IDLE, and sets timeout_o (sticky until reset).
  - After a timeout, a late slave R/B beat arriving while the FSM is in IDLE is accepted (ready = 1) and dropped.
- ARB_TIMEOUT_EN undefined: no counter. The FSM waits forever and timeout_o is tied to 0.

Test Plan:
- Reset check: rst_n low -> all valids/readies = 0, timeout_o = 0. Release, no requests for 10 cycles -> outputs unchanged.
- Single read: master0 ARs addr 0x8000_0000, slave returns data 0x0000_0013_0000_0297 after 3 cycles -> s_ar_valid_o high on cycle 1. Master0 gets that data with resp 0. m_r_valid_o[1] = 0 throughout.
- Fairness: both masters hold m_ar_valid_i continuously for 6 reads -> grant order 0,1,0,1,0,1.
- Concurrent: master0 reads 0x8000_0100 while master1 writes data 0xdead_beef with strb 0x0f to 0x8000_0200, W presented 2 cycles before AW -> both complete, and B goes only to master1.
- Same-cycle AW/W handshake -> W_RESP is entered on the next cycle, no extra stall.
- With ARB_TIMEOUT_EN and TIMEOUT = 20: the slave never asserts s_r_valid_i -> at 20 cycles the master sees r_valid with resp 2'b10 and data 0, and timeout_o = 1. The next read from master1 completes normally.
